// File: rtl/spi_axi_master_arbiter.sv
// ---------------------------------------------------------------------------
// spi_axi_master_arbiter
//
// Purpose:
//   Shares one AXI4 master port between two SPI-slave AXI plugs (for
//   example a local SPI target and a multichip-bridge SPI target). Reads and
//   writes are arbitrated independently. Each direction carries one
//   transaction at a time, and its responses are routed back to the
//   requester that owns that transaction. Everything runs in the axi_aclk
//   domain.
//
// Build option:
//   SPI_AXI_ARB_FIXED_PRIO_EN - when defined, both directions use fixed
//   priority (requester 0 beats requester 1) and no round-robin pointers
//   exist. When undefined (default), each direction round-robins with its
//   own pointer.
//
// Ports:
//   axi_aclk, axi_areset     clock; asynchronous active-high reset
//   s_aw_* / s_w_* / s_b_*   per-requester write channels; bit/slice i is
//                            requester i (payloads: [i*AXP +: AXP])
//   s_ar_* / s_r_*           per-requester read channels
//   m_aw_* / m_w_* / m_b_*   shared master write channels
//   m_ar_* / m_r_*           shared master read channels
//   wr_owner, rd_owner       requester index owning each direction
//   wr_busy, rd_busy         direction FSM is not idle
//   proto_err                sticky: requester W-last disagreed with the
//                            beat count implied by AW len
//
// Payload packing (AW/AR): {addr, len[7:0], size[2:0], burst[1:0], id}.
// B resp and R data/resp/last are not muxed. Requesters take them straight
// from the master port, and only the valid/ready pair is steered.
//
// Handshake rule, applying to every channel here: a beat transfers on a
// rising clock edge where valid and ready are both high. valid does not
// depend on ready. Only the current owner's ready/valid is ever steered.
// Non-owner readies and response valids are held at 0.
// ---------------------------------------------------------------------------
module spi_axi_master_arbiter #(
  parameter  int AXI_ADDR_WIDTH = 32,
  parameter  int AXI_DATA_WIDTH = 64,
  parameter  int AXI_ID_WIDTH   = 3,
  localparam int AXP            = AXI_ADDR_WIDTH + 8 + 3 + 2 + AXI_ID_WIDTH,
  localparam int SW             = AXI_DATA_WIDTH / 8
) (
  input  logic                        axi_aclk,
  input  logic                        axi_areset,
  // requester write side
  input  logic [1:0]                  s_aw_valid,
  input  logic [2*AXP-1:0]            s_aw_pld,
  output logic [1:0]                  s_aw_ready,
  input  logic [1:0]                  s_w_valid,
  input  logic [2*AXI_DATA_WIDTH-1:0] s_w_data,
  input  logic [2*SW-1:0]             s_w_strb,
  input  logic [1:0]                  s_w_last,
  output logic [1:0]                  s_w_ready,
  output logic [1:0]                  s_b_valid,
  input  logic [1:0]                  s_b_ready,
  // requester read side
  input  logic [1:0]                  s_ar_valid,
  input  logic [2*AXP-1:0]            s_ar_pld,
  output logic [1:0]                  s_ar_ready,
  output logic [1:0]                  s_r_valid,
  input  logic [1:0]                  s_r_ready,
  // master write side
  output logic                        m_aw_valid,
  output logic [AXP-1:0]              m_aw_pld,
  input  logic                        m_aw_ready,
  output logic                        m_w_valid,
  output logic [AXI_DATA_WIDTH-1:0]   m_w_data,
  output logic [SW-1:0]               m_w_strb,
  output logic                        m_w_last,
  input  logic                        m_w_ready,
  input  logic                        m_b_valid,
  input  logic [1:0]                  m_b_resp,
  output logic                        m_b_ready,
  // master read side
  output logic                        m_ar_valid,
  output logic [AXP-1:0]              m_ar_pld,
  input  logic                        m_ar_ready,
  input  logic                        m_r_valid,
  input  logic [AXI_DATA_WIDTH-1:0]   m_r_data,
  input  logic [1:0]                  m_r_resp,
  input  logic                        m_r_last,
  output logic                        m_r_ready,
  // status
  output logic                        wr_owner,
  output logic                        rd_owner,
  output logic                        wr_busy,
  output logic                        rd_busy,
  output logic                        proto_err
);

  // Bit position of len inside a packed AW/AR payload.
  localparam int LEN_LSB = AXI_ID_WIDTH + 2 + 3;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  wr_state_t wr_state, wr_state_d;
  rd_state_t rd_state, rd_state_d;

  logic [7:0] wlen_q;
  logic [7:0] wcnt;

  logic wr_grant, wr_aw_hs, wr_w_hs;
  logic rd_grant;
  logic wr_winner, rd_winner;

  // Per-requester slices of the packed inputs.
  logic [AXP-1:0]            aw_pld0, aw_pld1, ar_pld0, ar_pld1;
  logic [AXI_DATA_WIDTH-1:0] w_data0, w_data1;
  logic [SW-1:0]             w_strb0, w_strb1;

  assign aw_pld0 = s_aw_pld[AXP-1:0];
  assign aw_pld1 = s_aw_pld[2*AXP-1:AXP];
  assign ar_pld0 = s_ar_pld[AXP-1:0];
  assign ar_pld1 = s_ar_pld[2*AXP-1:AXP];
  assign w_data0 = s_w_data[AXI_DATA_WIDTH-1:0];
  assign w_data1 = s_w_data[2*AXI_DATA_WIDTH-1:AXI_DATA_WIDTH];
  assign w_strb0 = s_w_strb[SW-1:0];
  assign w_strb1 = s_w_strb[2*SW-1:SW];

  // These inputs reach the requesters by direct fan-out. The arbiter
  // itself never looks at them.
  logic unused_fanout;
  assign unused_fanout = ^{m_b_resp, m_r_data, m_r_resp};

  // -------------------------------------------------------------------------
  // Winner selection
  // -------------------------------------------------------------------------
`ifdef SPI_AXI_ARB_FIXED_PRIO_EN
  // Requester 0 wins whenever it is requesting.
  assign wr_winner = ~s_aw_valid[0];
  assign rd_winner = ~s_ar_valid[0];
`else
  logic wr_ptr, rd_ptr;

  // The requester at the pointer wins if it is asking. Otherwise the other
  // one wins. The pointer then moves past the winner.
  assign wr_winner = s_aw_valid[wr_ptr] ? wr_ptr : ~wr_ptr;
  assign rd_winner = s_ar_valid[rd_ptr] ? rd_ptr : ~rd_ptr;

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (wr_grant) wr_ptr <= ~wr_winner;
      if (rd_grant) rd_ptr <= ~rd_winner;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Write direction
  // -------------------------------------------------------------------------
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      wr_state  <= W_IDLE;
      wr_owner  <= 1'b0;
      wlen_q    <= 8'd0;
      wcnt      <= 8'd0;
      proto_err <= 1'b0;
    end else begin
      wr_state <= wr_state_d;
      if (wr_grant) wr_owner <= wr_winner;
      if (wr_aw_hs) begin
        wlen_q <= m_aw_pld[LEN_LSB +: 8];
        wcnt   <= 8'd0;
      end
      if (wr_w_hs) begin
        wcnt <= wcnt + 8'd1;
        // The requester's own last flag is only checked. The beat count
        // taken from AW len is what marks the end of the burst.
        if (s_w_last[wr_owner] != m_w_last) proto_err <= 1'b1;
      end
    end
  end

  always_comb begin
    wr_state_d = wr_state;
    wr_grant   = 1'b0;
    wr_aw_hs   = 1'b0;
    wr_w_hs    = 1'b0;
    m_aw_valid = 1'b0;
    m_aw_pld   = '0;
    s_aw_ready = 2'b00;
    m_w_valid  = 1'b0;
    m_w_data   = '0;
    m_w_strb   = '0;
    m_w_last   = 1'b0;
    s_w_ready  = 2'b00;
    s_b_valid  = 2'b00;
    m_b_ready  = 1'b0;
    case (wr_state)
      W_IDLE: begin
        if (|s_aw_valid) begin
          wr_grant   = 1'b1;
          wr_state_d = W_ADDR;
        end
      end
      W_ADDR: begin
        m_aw_valid           = s_aw_valid[wr_owner];
        m_aw_pld             = wr_owner ? aw_pld1 : aw_pld0;
        s_aw_ready[wr_owner] = m_aw_ready;
        if (m_aw_valid && m_aw_ready) begin
          wr_aw_hs   = 1'b1;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        m_w_valid           = s_w_valid[wr_owner];
        m_w_data            = wr_owner ? w_data1 : w_data0;
        m_w_strb            = wr_owner ? w_strb1 : w_strb0;
        m_w_last            = (wcnt == wlen_q);
        s_w_ready[wr_owner] = m_w_ready;
        if (m_w_valid && m_w_ready) begin
          wr_w_hs = 1'b1;
          if (m_w_last) wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        s_b_valid[wr_owner] = m_b_valid;
        m_b_ready           = s_b_ready[wr_owner];
        if (m_b_valid && m_b_ready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  assign wr_busy = (wr_state != W_IDLE);

  // -------------------------------------------------------------------------
  // Read direction
  // -------------------------------------------------------------------------
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      rd_state <= R_IDLE;
      rd_owner <= 1'b0;
    end else begin
      rd_state <= rd_state_d;
      if (rd_grant) rd_owner <= rd_winner;
    end
  end

  always_comb begin
    rd_state_d = rd_state;
    rd_grant   = 1'b0;
    m_ar_valid = 1'b0;
    m_ar_pld   = '0;
    s_ar_ready = 2'b00;
    s_r_valid  = 2'b00;
    m_r_ready  = 1'b0;
    case (rd_state)
      R_IDLE: begin
        if (|s_ar_valid) begin
          rd_grant   = 1'b1;
          rd_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        m_ar_valid           = s_ar_valid[rd_owner];
        m_ar_pld             = rd_owner ? ar_pld1 : ar_pld0;
        s_ar_ready[rd_owner] = m_ar_ready;
        if (m_ar_valid && m_ar_ready) rd_state_d = R_DATA;
      end
      R_DATA: begin
        s_r_valid[rd_owner] = m_r_valid;
        m_r_ready           = s_r_ready[rd_owner];
        if (m_r_valid && m_r_ready && m_r_last) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  assign rd_busy = (rd_state != R_IDLE);

endmodule

// File: tb/tb_spi_axi_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spi_axi_master_arbiter
//
// Directed bench for spi_axi_master_arbiter. The bench drives both requester
// sides and plays the master-side slave. Inputs change 1 ns after a rising
// edge. Outputs are sampled 1 ns later, well clear of the next edge.
// Expected values are written out by hand for each step.
// ---------------------------------------------------------------------------
module tb_spi_axi_master_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int IW  = 3;
  localparam int AXP = AW + 8 + 3 + 2 + IW;
  localparam int SW  = DW / 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // requester side
  logic [1:0]       s_aw_valid, s_aw_ready, s_w_valid, s_w_last, s_w_ready;
  logic [1:0]       s_b_valid, s_b_ready, s_ar_valid, s_ar_ready;
  logic [1:0]       s_r_valid, s_r_ready;
  logic [2*AXP-1:0] s_aw_pld, s_ar_pld;
  logic [2*DW-1:0]  s_w_data;
  logic [2*SW-1:0]  s_w_strb;
  // master side
  logic           m_aw_valid, m_aw_ready, m_w_valid, m_w_last, m_w_ready;
  logic           m_b_valid, m_b_ready, m_ar_valid, m_ar_ready;
  logic           m_r_valid, m_r_last, m_r_ready;
  logic [AXP-1:0] m_aw_pld, m_ar_pld;
  logic [DW-1:0]  m_w_data, m_r_data;
  logic [SW-1:0]  m_w_strb;
  logic [1:0]     m_b_resp, m_r_resp;
  // status
  logic wr_owner, rd_owner, wr_busy, rd_busy, proto_err;

  spi_axi_master_arbiter #(
    .AXI_ADDR_WIDTH(AW),
    .AXI_DATA_WIDTH(DW),
    .AXI_ID_WIDTH  (IW)
  ) dut (
    .axi_aclk  (clk),
    .axi_areset(rst),
    .s_aw_valid(s_aw_valid), .s_aw_pld(s_aw_pld), .s_aw_ready(s_aw_ready),
    .s_w_valid (s_w_valid),  .s_w_data(s_w_data), .s_w_strb(s_w_strb),
    .s_w_last  (s_w_last),   .s_w_ready(s_w_ready),
    .s_b_valid (s_b_valid),  .s_b_ready(s_b_ready),
    .s_ar_valid(s_ar_valid), .s_ar_pld(s_ar_pld), .s_ar_ready(s_ar_ready),
    .s_r_valid (s_r_valid),  .s_r_ready(s_r_ready),
    .m_aw_valid(m_aw_valid), .m_aw_pld(m_aw_pld), .m_aw_ready(m_aw_ready),
    .m_w_valid (m_w_valid),  .m_w_data(m_w_data), .m_w_strb(m_w_strb),
    .m_w_last  (m_w_last),   .m_w_ready(m_w_ready),
    .m_b_valid (m_b_valid),  .m_b_resp(m_b_resp), .m_b_ready(m_b_ready),
    .m_ar_valid(m_ar_valid), .m_ar_pld(m_ar_pld), .m_ar_ready(m_ar_ready),
    .m_r_valid (m_r_valid),  .m_r_data(m_r_data), .m_r_resp(m_r_resp),
    .m_r_last  (m_r_last),   .m_r_ready(m_r_ready),
    .wr_owner  (wr_owner),   .rd_owner(rd_owner),
    .wr_busy   (wr_busy),    .rd_busy(rd_busy),
    .proto_err (proto_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  // {addr, len, size, burst, id}
  function automatic logic [AXP-1:0] mk_pld(input logic [AW-1:0] addr,
                                             input logic [7:0] len,
                                             input logic [IW-1:0] id);
    return {addr, len, 3'd3, 2'd1, id};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    s_aw_valid = '0; s_aw_pld = '0; s_w_valid = '0; s_w_data = '0;
    s_w_strb = '0; s_w_last = '0; s_b_ready = '0; s_ar_valid = '0;
    s_ar_pld = '0; s_r_ready = '0;
    m_aw_ready = 1'b0; m_w_ready = 1'b0; m_b_valid = 1'b0; m_b_resp = '0;
    m_ar_ready = 1'b0; m_r_valid = 1'b0; m_r_data = '0; m_r_resp = '0;
    m_r_last = 1'b0;
  endtask

  // Hard stop in case the sequence below ever stalls.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [AXP-1:0] p0, p1;
    logic [1:0]     oh;
    logic           e;
    logic           exp_rdy, hs, done;
    int             idx, cyc;
    logic           exp_own [3];

    // ---------------- reset ----------------
    clear_inputs();
    rst = 1'b1;
    #1;
    chk("rst_wr_busy", wr_busy, 0);
    chk("rst_m_aw_valid", m_aw_valid, 0);
    tick(); tick();
    rst = 1'b0;
    m_aw_ready = 1'b1; m_w_ready = 1'b1; m_ar_ready = 1'b1;
    settle();
    chk("rst_rd_busy", rd_busy, 0);
    chk("rst_wr_owner", wr_owner, 0);
    chk("rst_rd_owner", rd_owner, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_m_aw_pld", m_aw_pld, 0);
    chk("rst_m_ar_valid", m_ar_valid, 0);
    chk("rst_s_aw_ready", s_aw_ready, 0);
    chk("rst_m_w_last", m_w_last, 0);

    // ---------------- 1: single write from req1, len=3 ----------------
    p1 = mk_pld(32'h1000_0040, 8'd3, 3'd5);
    s_aw_pld[AXP +: AXP] = p1;
    s_aw_valid = 2'b10;
    settle();
    chk("t1_idle_aw_ready", s_aw_ready, 2'b00);
    chk("t1_idle_busy", wr_busy, 0);
    tick(); settle();
    chk("t1_owner", wr_owner, 1);
    chk("t1_m_aw_valid", m_aw_valid, 1);
    chk("t1_m_aw_pld", m_aw_pld, p1);
    chk("t1_s_aw_ready", s_aw_ready, 2'b10);
    chk("t1_busy", wr_busy, 1);
    tick();
    s_aw_valid = 2'b00;
    s_w_valid  = 2'b10;
    for (int k = 0; k < 4; k++) begin
      s_w_data[DW +: DW] = 64'hA0 + 64'(k);
      s_w_strb[SW +: SW] = 8'hF0;
      s_w_last = (k == 3) ? 2'b10 : 2'b00;
      settle();
      chk("t1_m_w_valid", m_w_valid, 1);
      chk("t1_m_w_data", m_w_data, 64'hA0 + 64'(k));
      chk("t1_m_w_strb", m_w_strb, 8'hF0);
      chk("t1_m_w_last", m_w_last, (k == 3));
      chk("t1_s_w_ready", s_w_ready, 2'b10);
      tick();
    end
    s_w_valid = 2'b00; s_w_last = 2'b00;
    m_b_valid = 1'b1; s_b_ready = 2'b10;
    settle();
    chk("t1_s_b_valid", s_b_valid, 2'b10);
    chk("t1_m_b_ready", m_b_ready, 1);
    chk("t1_resp_w_ready", s_w_ready, 2'b00);
    tick();
    m_b_valid = 1'b0; s_b_ready = 2'b00;
    settle();
    chk("t1_busy_fall", wr_busy, 0);
    chk("t1_b_valid_off", s_b_valid, 2'b00);
    chk("t1_proto_err", proto_err, 0);

    // ---------------- 2: simultaneous AW, len=0, three rounds ----------------
`ifdef SPI_AXI_ARB_FIXED_PRIO_EN
    exp_own[0] = 1'b0; exp_own[1] = 1'b0; exp_own[2] = 1'b0;
`else
    exp_own[0] = 1'b0; exp_own[1] = 1'b1; exp_own[2] = 1'b0;
`endif
    p0 = mk_pld(32'h2000_0000, 8'd0, 3'd1);
    p1 = mk_pld(32'h3000_0000, 8'd0, 3'd2);
    s_aw_pld = {p1, p0};
    s_aw_valid = 2'b11;
    s_w_valid = 2'b11; s_w_last = 2'b11;
    s_w_data = {64'hD1, 64'hD0};
    m_b_valid = 1'b1; s_b_ready = 2'b11;
    for (int r = 0; r < 3; r++) begin
      e  = exp_own[r];
      oh = e ? 2'b10 : 2'b01;
      settle();
      chk("t2_idle_busy", wr_busy, 0);
      tick(); settle();
      chk("t2_owner", wr_owner, e);
      chk("t2_m_aw_pld", m_aw_pld, e ? p1 : p0);
      chk("t2_s_aw_ready", s_aw_ready, oh);
      tick(); settle();
      chk("t2_m_w_last", m_w_last, 1);
      chk("t2_m_w_data", m_w_data, e ? 64'hD1 : 64'hD0);
      chk("t2_s_w_ready", s_w_ready, oh);
      tick(); settle();
      chk("t2_s_b_valid", s_b_valid, oh);
      tick();
    end
    clear_inputs();
    m_aw_ready = 1'b1; m_w_ready = 1'b1; m_ar_ready = 1'b1;
    tick(); settle();
    chk("t2_stays_idle", wr_busy, 0);
    chk("t2_proto_err", proto_err, 0);

    // ---------------- 3: early s_w_last from req0, len=3 ----------------
    p0 = mk_pld(32'h4000_0000, 8'd3, 3'd0);
    s_aw_pld[0 +: AXP] = p0;
    s_aw_valid = 2'b01;
    tick(); settle();
    chk("t3_owner", wr_owner, 0);
    chk("t3_m_aw_pld", m_aw_pld, p0);
    tick();
    s_aw_valid = 2'b00;
    s_w_valid  = 2'b01;
    for (int k = 0; k < 4; k++) begin
      s_w_data[0 +: DW] = 64'hB0 + 64'(k);
      s_w_last = (k == 1) ? 2'b01 : 2'b00;
      settle();
      chk("t3_m_w_last", m_w_last, (k == 3));
      chk("t3_proto_err", proto_err, (k >= 2));
      tick();
    end
    s_w_valid = 2'b00; s_w_last = 2'b00;
    m_b_valid = 1'b1; s_b_ready = 2'b01;
    settle();
    chk("t3_s_b_valid", s_b_valid, 2'b01);
    tick();
    m_b_valid = 1'b0; s_b_ready = 2'b00;
    settle();
    chk("t3_busy_fall", wr_busy, 0);
    chk("t3_proto_err_sticky", proto_err, 1);

    // ---------------- 4: read req0 len=7 alongside write req1 len=1 ----------------
    p1 = mk_pld(32'h5000_0000, 8'd1, 3'd3);
    p0 = mk_pld(32'h6000_0000, 8'd7, 3'd4);
    s_aw_pld[AXP +: AXP] = p1;
    s_ar_pld[0 +: AXP]   = p0;
    s_aw_valid = 2'b10;
    s_ar_valid = 2'b01;
    tick(); settle();
    chk("t4_wr_owner", wr_owner, 1);
    chk("t4_rd_owner", rd_owner, 0);
    chk("t4_m_aw_pld", m_aw_pld, p1);
    chk("t4_m_ar_valid", m_ar_valid, 1);
    chk("t4_m_ar_pld", m_ar_pld, p0);
    chk("t4_s_ar_ready", s_ar_ready, 2'b01);
    tick();
    s_aw_valid = 2'b00; s_ar_valid = 2'b00;
    s_b_ready = 2'b10; s_r_ready = 2'b01;
    for (int c = 0; c < 9; c++) begin
      s_w_valid = (c < 2) ? 2'b10 : 2'b00;
      s_w_last  = (c == 1) ? 2'b10 : 2'b00;
      s_w_data[DW +: DW] = 64'hC0 + 64'(c);
      m_b_valid = (c == 2);
      m_r_valid = (c < 8);
      m_r_last  = (c == 7);
      m_r_data  = 64'(c);
      settle();
      if (c < 8) begin
        chk("t4_s_r_valid", s_r_valid, 2'b01);
        chk("t4_m_r_ready", m_r_ready, 1);
      end else begin
        chk("t4_rd_done", rd_busy, 0);
        chk("t4_s_r_valid_off", s_r_valid, 2'b00);
      end
      if (c < 2) begin
        chk("t4_m_w_last", m_w_last, (c == 1));
        chk("t4_s_w_ready", s_w_ready, 2'b10);
      end else if (c == 2) begin
        chk("t4_s_b_valid", s_b_valid, 2'b10);
        chk("t4_m_b_ready", m_b_ready, 1);
      end else begin
        chk("t4_wr_done", wr_busy, 0);
        chk("t4_s_b_valid_off", s_b_valid, 2'b00);
      end
      tick();
    end
    s_w_valid = 2'b00; s_w_last = 2'b00; m_b_valid = 1'b0; s_b_ready = 2'b00;
    m_r_valid = 1'b0; m_r_last = 1'b0; s_r_ready = 2'b00;

    // ---------------- 5: R backpressure from req1, len=3 ----------------
    p1 = mk_pld(32'h7000_0000, 8'd3, 3'd6);
    s_ar_pld[AXP +: AXP] = p1;
    s_ar_valid = 2'b10;
    tick(); settle();
    chk("t5_rd_owner", rd_owner, 1);
    tick();
    s_ar_valid = 2'b00;
    m_r_valid  = 1'b1;
    idx = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 20) begin
      exp_rdy   = !(cyc >= 1 && cyc <= 5);
      s_r_ready = exp_rdy ? 2'b10 : 2'b00;
      m_r_data  = 64'hE0 + 64'(idx);
      m_r_last  = (idx == 3);
      settle();
      chk("t5_m_r_ready", m_r_ready, exp_rdy);
      chk("t5_s_r_valid", s_r_valid, 2'b10);
      hs = m_r_ready;
      tick();
      if (hs) begin
        if (idx == 3) done = 1'b1;
        idx++;
      end
      cyc++;
    end
    m_r_valid = 1'b0; m_r_last = 1'b0; s_r_ready = 2'b00;
    settle();
    chk("t5_beats", idx, 4);
    chk("t5_cycles", cyc, 9);
    chk("t5_rd_done", rd_busy, 0);

    // ---------------- 6: reset during write DATA beat 2 ----------------
    p1 = mk_pld(32'h8000_0000, 8'd3, 3'd7);
    s_aw_pld[AXP +: AXP] = p1;
    s_aw_valid = 2'b10;
    tick(); settle();
    chk("t6_owner", wr_owner, 1);
    tick();
    s_aw_valid = 2'b00;
    s_w_valid  = 2'b10;
    s_w_data[DW +: DW] = 64'h11;
    tick();
    s_w_data[DW +: DW] = 64'h22;
    settle();
    chk("t6_beat2_valid", m_w_valid, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_m_w_valid", m_w_valid, 0);
    chk("t6_rst_m_w_data", m_w_data, 0);
    chk("t6_rst_s_w_ready", s_w_ready, 2'b00);
    chk("t6_rst_wr_busy", wr_busy, 0);
    chk("t6_rst_owner", wr_owner, 0);
    chk("t6_rst_proto_err", proto_err, 0);
    clear_inputs();
    tick();
    rst = 1'b0;
    m_aw_ready = 1'b1; m_w_ready = 1'b1; m_ar_ready = 1'b1;
    s_aw_pld[AXP +: AXP] = p1;
    s_aw_valid = 2'b10;
    settle();
    chk("t6_post_idle", wr_busy, 0);
    tick(); settle();
    chk("t6_regrant_busy", wr_busy, 1);
    chk("t6_regrant_owner", wr_owner, 1);
    chk("t6_regrant_aw_valid", m_aw_valid, 1);
    chk("t6_regrant_aw_pld", m_aw_pld, p1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
